// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator operation selector.
//   - Opcode values presented to the ALU controller (0 means no operation).
//   - State encoding of the selector FSM.
// No ports: package only.
// -----------------------------------------------------------------------------
package calc_pkg;

    // Opcode values; bit i of the button vector maps to opcode i+1.
    localparam int IDLE = 0;
    localparam int ADD  = 1;
    localparam int SUB  = 2;
    localparam int MUL  = 3;
    localparam int XOR  = 4;

    // Selector FSM states.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,  // waiting for any button
        S_FILT     = 2'd1,  // candidate captured, checking it stays put
        S_VALID    = 2'd2,  // opcode offered, waiting for op_ready
        S_WAIT_REL = 2'd3   // press consumed or rejected, waiting for release
    } state_e;

endpackage

// File: rtl/calc_op_select_chk.sv
// -----------------------------------------------------------------------------
// calc_op_select_chk
// Interface properties of calc_op_select, observed from its ports only.
//   clk, rst, op_out, op_valid, op_ready, err, busy : inputs mirroring the
//   selector's ports of the same names.
// -----------------------------------------------------------------------------
module calc_op_select_chk #(
    parameter int OPW = 3
) (
    input logic           clk,
    input logic           rst,
    input logic [OPW-1:0] op_out,
    input logic           op_valid,
    input logic           op_ready,
    input logic           err,
    input logic           busy
);

    // No stale opcode may be visible while nothing is offered.
    a_idle_opcode : assert property (@(posedge clk) disable iff (rst)
        !op_valid |-> (op_out == '0))
        else $error("calc_op_select_chk: op_out nonzero while op_valid low");

    // A rejection and an offer never coexist.
    a_err_excl : assert property (@(posedge clk) disable iff (rst)
        err |-> !op_valid)
        else $error("calc_op_select_chk: err together with op_valid");

    // Any activity on the outputs implies the FSM is busy.
    a_busy : assert property (@(posedge clk) disable iff (rst)
        (op_valid || err) |-> busy)
        else $error("calc_op_select_chk: output active while not busy");

    // An offer that is not taken stays put with the same opcode.
    a_hold : assert property (@(posedge clk) disable iff (rst)
        (op_valid && !op_ready) |=> (op_valid && $stable(op_out)))
        else $error("calc_op_select_chk: offer changed before handshake");

endmodule

// File: rtl/onehot_enc.sv
// -----------------------------------------------------------------------------
// onehot_enc
// Combinational classifier for a button vector.
//   vec       : input,  N bits, candidate button vector
//   is_onehot : output, 1 bit,  exactly one bit of vec is set
//   idx       : output, W bits, index of the lowest set bit of vec
//               (the index of the only set bit when vec is one-hot,
//               0 when vec is all zero)
// The lowest-set-bit index serves both the strict build, where it is only
// used when is_onehot is high, and the priority build, where a multi-hot
// vector resolves to its lowest button.
// -----------------------------------------------------------------------------
module onehot_enc
    import calc_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] vec,
    output logic         is_onehot,
    output logic [W-1:0] idx
);

    logic found_s;
    logic multi_s;

    // Scan from bit 0 upward: the first set bit gives idx, any later one marks multi-hot.
    always_comb begin
        idx       = '0;
        found_s   = 1'b0;
        multi_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i] && !found_s) begin
                idx     = W'(i);
                found_s = 1'b1;
            end else if (vec[i]) begin
                multi_s = 1'b1;
            end else begin
                multi_s = multi_s;
            end
        end
        is_onehot = found_s & ~multi_s;
    end

endmodule

// File: rtl/calc_op_select.sv
// -----------------------------------------------------------------------------
// calc_op_select
// Operation selector of the calculator: filters the synchronised operation
// buttons for stability, rejects multi-button presses, and offers exactly one
// binary opcode per press to the ALU controller on a valid/ready handshake.
// A new press is only considered after every button has been released.
//
// Ports:
//   clk      : input,  1      rising-edge clock
//   rst      : input,  1      synchronous active-high reset (highest priority)
//   sel      : input,  N_OPS  synchronised button vector, one-hot = legal
//   op_out   : output, OPW    registered opcode, 0 whenever op_valid is low
//   op_valid : output, 1      opcode offered
//   op_ready : input,  1      consumer takes op_out when op_valid & op_ready
//   err      : output, 1      one-cycle pulse on a rejected stable multi-hot
//   busy     : output, 1      FSM is outside S_IDLE
//
// Build option:
//   CALC_OP_PRIORITY_EN  when defined, a stable multi-hot press resolves to
//                        its lowest set button and err is never raised.
// -----------------------------------------------------------------------------
module calc_op_select
    import calc_pkg::*;
#(
    parameter int N_OPS         = 4,
    parameter int OPW           = $clog2(N_OPS + 1),
    parameter int STABLE_CYCLES = 4,
    parameter int CNTW          = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_OPS-1:0] sel,
    output logic [OPW-1:0]   op_out,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             err,
    output logic             busy
);

    localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(STABLE_CYCLES - 1);
    localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);
    localparam logic [OPW-1:0]   OP_ONE   = OPW'(1);
    localparam logic [OPW-1:0]   OP_IDLE  = OPW'(IDLE);

    state_e             state_q;
    state_e             state_d;
    logic [N_OPS-1:0]   cand_q;
    logic [N_OPS-1:0]   cand_d;
    logic [CNTW-1:0]    cnt_q;
    logic [CNTW-1:0]    cnt_d;
    logic [OPW-1:0]     op_out_q;
    logic [OPW-1:0]     op_out_d;
    logic               op_valid_q;
    logic               op_valid_d;
    logic               err_q;
    logic               err_d;

    logic               enc_onehot_s;
    logic [OPW-1:0]     enc_idx_s;
    logic               accept_s;
    logic               sel_active_s;
    logic               sel_match_s;
    logic               cnt_last_s;

    // Classify the held candidate, not the live input, so the decision uses
    // exactly the vector that passed the stability filter.
    onehot_enc #(
        .N (N_OPS),
        .W (OPW)
    ) u_enc (
        .vec       (cand_q),
        .is_onehot (enc_onehot_s),
        .idx       (enc_idx_s)
    );

`ifdef CALC_OP_PRIORITY_EN
    // Candidate is never zero in S_FILT, so any stable press yields an opcode.
    assign accept_s = 1'b1;
`else
    assign accept_s = enc_onehot_s;
`endif

    assign sel_active_s = (sel != '0);
    assign sel_match_s  = (sel == cand_q);
    assign cnt_last_s   = (cnt_q == CNT_LAST);

    // Next-state, filter counter and output register inputs.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        op_out_d   = op_out_q;
        op_valid_d = op_valid_q;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_active_s) begin
                    cand_d  = sel;
                    cnt_d   = '0;
                    state_d = S_FILT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILT: begin
                if (!sel_match_s) begin
                    // Bounce or release before the filter completed: drop silently.
                    state_d = S_IDLE;
                end else if (cnt_last_s) begin
                    if (accept_s) begin
                        op_out_d   = enc_idx_s + OP_ONE;
                        op_valid_d = 1'b1;
                        state_d    = S_VALID;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_WAIT_REL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_VALID: begin
                // Offer is frozen here; only the handshake moves us on.
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    op_out_d   = OP_IDLE;
                    state_d    = S_WAIT_REL;
                end else begin
                    state_d = S_VALID;
                end
            end
            S_WAIT_REL: begin
                if (!sel_active_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end
            default: begin
                state_d    = S_IDLE;
                op_valid_d = 1'b0;
                op_out_d   = OP_IDLE;
            end
        endcase
    end

    // State, filter and output registers; reset discards any pending opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            op_out_q   <= OP_IDLE;
            op_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            op_out_q   <= op_out_d;
            op_valid_q <= op_valid_d;
            err_q      <= err_d;
        end
    end

    assign op_out   = op_out_q;
    assign op_valid = op_valid_q;
    assign err      = err_q;
    assign busy     = (state_q != S_IDLE);

endmodule
